controlador_asc: RTL and testbench

//  Parametrised single-car elevator controller; successor to the fixed-sequence test cars.

---
 rtl/controlador_asc_pkg.sv | 16 +
 rtl/temporizador_asc.sv | 35 +++
 rtl/controlador_asc.sv | 178 +++++++++++++++++
 tb/tb_controlador_asc.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/controlador_asc_pkg.sv
// Shared encodings for the elevator controller: FSM states and travel direction.
package controlador_asc_pkg;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        MOVIENDO = 2'd1,
        PUERTAS  = 2'd2
    } estado_e;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_SUBE = 2'b01,
        DIR_BAJA = 2'b10
    } dir_e;

endpackage

// File: rtl/temporizador_asc.sv
// Cycle timer shared by travel and door dwell: counts 0..limite_i, flags the last cycle,
// and wraps to 0 on its own. arranque_i forces the count back to 0.
module temporizador_asc #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arranque_i,
    input  logic [CNT_W-1:0] limite_i,
    output logic             fin_c
);

    logic [CNT_W-1:0] cuenta_q;
    logic [CNT_W-1:0] cuenta_d;

    assign fin_c = (cuenta_q == limite_i);

    // Next count: restart on request or after the final cycle, otherwise increment.
    always_comb begin
        cuenta_d = cuenta_q + CNT_W'(1);
        if (arranque_i || fin_c) begin
            cuenta_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

endmodule

// File: rtl/controlador_asc.sv
// Single-car elevator controller: latches floor calls and serves them with a SCAN policy,
// timing floor-to-floor travel and door dwell in clock cycles.
module controlador_asc
    import controlador_asc_pkg::*;
#(
    parameter int unsigned N_PISOS  = 4,
    parameter int unsigned T_VIAJE  = 8,
    parameter int unsigned T_PUERTA = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_PISOS-1:0]         llamada,
    output logic [$clog2(N_PISOS)-1:0] piso,
    output logic [1:0]                 direccion,
    output logic                       puertas_abiertas,
    output logic [N_PISOS-1:0]         llamadas_pendientes
);

    localparam int unsigned PISO_W = $clog2(N_PISOS);
    localparam int unsigned T_MAX  = (T_VIAJE > T_PUERTA) ? T_VIAJE : T_PUERTA;
    localparam int unsigned CNT_W  = $clog2(T_MAX + 1);

    // One-hot mask of floor p.
    function automatic logic [N_PISOS-1:0] uno_en(input logic [PISO_W-1:0] p);
        uno_en = '0;
        for (int i = 0; i < N_PISOS; i++) begin
            if (PISO_W'(i) == p) uno_en[i] = 1'b1;
        end
    endfunction

    // Any pending call strictly above floor p.
    function automatic logic hay_arriba(input logic [N_PISOS-1:0] m, input logic [PISO_W-1:0] p);
        hay_arriba = 1'b0;
        for (int i = 0; i < N_PISOS; i++) begin
            if ((PISO_W'(i) > p) && m[i]) hay_arriba = 1'b1;
        end
    endfunction

    // Any pending call strictly below floor p.
    function automatic logic hay_abajo(input logic [N_PISOS-1:0] m, input logic [PISO_W-1:0] p);
        hay_abajo = 1'b0;
        for (int i = 0; i < N_PISOS; i++) begin
            if ((PISO_W'(i) < p) && m[i]) hay_abajo = 1'b1;
        end
    endfunction

    estado_e             estado_q, estado_d;
    dir_e                dir_q, dir_d;
    logic [PISO_W-1:0]   piso_q, piso_d, piso_sig;
    logic                puertas_q, puertas_d;
    logic [N_PISOS-1:0]  pend_q, pend_d;
    logic [N_PISOS-1:0]  aqui_mask, servir, llamada_ef;
    logic                aqui, arriba, abajo, baja, sigue;
    logic                arranque, fin;
    logic [CNT_W-1:0]    limite;

    temporizador_asc #(
        .CNT_W (CNT_W)
    ) u_temporizador (
        .clk        (clk),
        .rst_n      (rst_n),
        .arranque_i (arranque),
        .limite_i   (limite),
        .fin_c      (fin)
    );

    // Call masks relative to the current floor and the floor the car is heading to.
    always_comb begin
        aqui_mask = uno_en(piso_q);
        aqui      = |(pend_q & aqui_mask);
        arriba    = hay_arriba(pend_q, piso_q);
        abajo     = hay_abajo(pend_q, piso_q);
        baja      = (dir_q == DIR_BAJA);
        piso_sig  = baja ? (piso_q - PISO_W'(1)) : (piso_q + PISO_W'(1));
        sigue     = baja ? hay_abajo(pend_q, piso_sig) : hay_arriba(pend_q, piso_sig);
    end

    // Next-state logic: SCAN policy, timer control and call bookkeeping.
    always_comb begin
        estado_d   = estado_q;
        dir_d      = dir_q;
        piso_d     = piso_q;
        puertas_d  = puertas_q;
        servir     = '0;
        arranque   = 1'b0;
        llamada_ef = llamada;
        limite     = CNT_W'(T_VIAJE - 1);

        unique case (estado_q)
            REPOSO: begin
                arranque  = 1'b1;
                dir_d     = DIR_IDLE;
                puertas_d = 1'b0;
                if (aqui) begin
                    estado_d  = PUERTAS;
                    puertas_d = 1'b1;
                    servir    = aqui_mask;
                end else if (arriba) begin
                    estado_d = MOVIENDO;
                    dir_d    = DIR_SUBE;
                end else if (abajo) begin
                    estado_d = MOVIENDO;
                    dir_d    = DIR_BAJA;
                end
            end

            MOVIENDO: begin
                if (fin) begin
                    piso_d = piso_sig;
                    if (|(pend_q & uno_en(piso_sig))) begin
                        estado_d  = PUERTAS;
                        puertas_d = 1'b1;
                        servir    = uno_en(piso_sig);
                    end else if (!sigue) begin
                        // End floor or nothing further ahead: settle and re-evaluate.
                        estado_d = REPOSO;
                        dir_d    = DIR_IDLE;
                    end
                end
            end

            PUERTAS: begin
                limite     = CNT_W'(T_PUERTA - 1);
                llamada_ef = llamada & ~aqui_mask;
                if (|(llamada & aqui_mask)) begin
                    // Call for this floor while open: keep the doors open longer.
                    arranque = 1'b1;
                end else if (fin) begin
                    puertas_d = 1'b0;
                    if (baja ? abajo : arriba) begin
                        estado_d = MOVIENDO;
                        if (baja) dir_d = DIR_BAJA;
                        else      dir_d = DIR_SUBE;
                    end else if (baja ? arriba : abajo) begin
                        estado_d = MOVIENDO;
                        if (baja) dir_d = DIR_SUBE;
                        else      dir_d = DIR_BAJA;
                    end else begin
                        estado_d = REPOSO;
                        dir_d    = DIR_IDLE;
                    end
                end
            end

            default: begin
                estado_d  = REPOSO;
                dir_d     = DIR_IDLE;
                puertas_d = 1'b0;
            end
        endcase

        // A floor being served this edge wins over a new call for it.
        pend_d = (pend_q | llamada_ef) & ~servir;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= REPOSO;
            dir_q     <= DIR_IDLE;
            piso_q    <= '0;
            puertas_q <= 1'b0;
            pend_q    <= '0;
        end else begin
            estado_q  <= estado_d;
            dir_q     <= dir_d;
            piso_q    <= piso_d;
            puertas_q <= puertas_d;
            pend_q    <= pend_d;
        end
    end

    assign piso                = piso_q;
    assign direccion           = dir_q;
    assign puertas_abiertas    = puertas_q;
    assign llamadas_pendientes = pend_q;

endmodule

// File: tb/tb_controlador_asc.sv
// Directed bench for controlador_asc (4 floors, 8-cycle travel, 4-cycle dwell).
// Expected output snapshots are queued with their due cycle and checked on the falling edge.
module tb_controlador_asc;

    localparam int unsigned N_PISOS  = 4;
    localparam int unsigned T_VIAJE  = 8;
    localparam int unsigned T_PUERTA = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] llamada;
    logic [1:0] piso;
    logic [1:0] direccion;
    logic       puertas_abiertas;
    logic [3:0] llamadas_pendientes;

    typedef struct {
        int         cyc;
        string      tag;
        logic [8:0] snap;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    controlador_asc #(
        .N_PISOS  (N_PISOS),
        .T_VIAJE  (T_VIAJE),
        .T_PUERTA (T_PUERTA)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .llamada             (llamada),
        .piso                (piso),
        .direccion           (direccion),
        .puertas_abiertas    (puertas_abiertas),
        .llamadas_pendientes (llamadas_pendientes)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Snapshot layout: {piso, direccion, puertas, pendientes}.
    function automatic logic [8:0] obs();
        return {piso, direccion, puertas_abiertas, llamadas_pendientes};
    endfunction

    task automatic chk(input string tag, input logic [8:0] o, input logic [8:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed piso/dir/puertas/pend=%b expected %b (cycle %0d)", tag, o, e, cyc);
        end
    endtask

    task automatic expect_at(input int c, input string tag, input logic [1:0] p,
                             input logic [1:0] d, input logic pu, input logic [3:0] m);
        exp_t e;
        e.cyc  = c;
        e.tag  = tag;
        e.snap = {p, d, pu, m};
        sb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] m);
        llamada = m;
        @(negedge clk);
        llamada = '0;
    endtask

    // Scoreboard: compare every entry that has come due.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, obs(), e.snap);
        end
    end

    initial begin
        int c;
        rst_n   = 1'b0;
        llamada = '0;
        #2;
        chk("reset", obs(), 9'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: idle at 0, call floor 2; extra call for 2 on the arrival edge is absorbed.
        c = cyc;
        expect_at(c + 1,  "t1_latch",  2'd0, 2'b00, 1'b0, 4'b0100);
        expect_at(c + 2,  "t1_dir",    2'd0, 2'b01, 1'b0, 4'b0100);
        expect_at(c + 9,  "t1_pre1",   2'd0, 2'b01, 1'b0, 4'b0100);
        expect_at(c + 10, "t1_piso1",  2'd1, 2'b01, 1'b0, 4'b0100);
        expect_at(c + 17, "t1_pre2",   2'd1, 2'b01, 1'b0, 4'b0100);
        expect_at(c + 18, "t1_open",   2'd2, 2'b01, 1'b1, 4'b0000);
        expect_at(c + 21, "t1_last",   2'd2, 2'b01, 1'b1, 4'b0000);
        expect_at(c + 22, "t1_close",  2'd2, 2'b00, 1'b0, 4'b0000);
        pulse(4'b0100);
        wait_until(c + 17);
        pulse(4'b0100);
        wait_until(c + 24);

        // 4: doors open at 2, hold-open call on the second open cycle.
        c = cyc;
        expect_at(c + 1,  "t4_latch",  2'd2, 2'b00, 1'b0, 4'b0100);
        expect_at(c + 2,  "t4_open",   2'd2, 2'b00, 1'b1, 4'b0000);
        expect_at(c + 4,  "t4_hold",   2'd2, 2'b00, 1'b1, 4'b0000);
        expect_at(c + 6,  "t4_hold6",  2'd2, 2'b00, 1'b1, 4'b0000);
        expect_at(c + 7,  "t4_hold7",  2'd2, 2'b00, 1'b1, 4'b0000);
        expect_at(c + 8,  "t4_close",  2'd2, 2'b00, 1'b0, 4'b0000);
        pulse(4'b0100);
        wait_until(c + 3);
        pulse(4'b0100);
        wait_until(c + 10);

        // Move down to floor 1 for the next steps.
        c = cyc;
        expect_at(c + 2,  "go1_dir",   2'd2, 2'b10, 1'b0, 4'b0010);
        expect_at(c + 10, "go1_open",  2'd1, 2'b10, 1'b1, 4'b0000);
        expect_at(c + 14, "go1_close", 2'd1, 2'b00, 1'b0, 4'b0000);
        pulse(4'b0010);
        wait_until(c + 16);

        // 3: idle at 1, call own floor -> doors only.
        c = cyc;
        expect_at(c + 1,  "t3_latch",  2'd1, 2'b00, 1'b0, 4'b0010);
        expect_at(c + 2,  "t3_open",   2'd1, 2'b00, 1'b1, 4'b0000);
        expect_at(c + 5,  "t3_last",   2'd1, 2'b00, 1'b1, 4'b0000);
        expect_at(c + 6,  "t3_close",  2'd1, 2'b00, 1'b0, 4'b0000);
        expect_at(c + 9,  "t3_still",  2'd1, 2'b00, 1'b0, 4'b0000);
        pulse(4'b0010);
        wait_until(c + 10);

        // 5: idle at 1, calls 3 and 0 together -> up first.
        c = cyc;
        expect_at(c + 1,  "t5_latch",  2'd1, 2'b00, 1'b0, 4'b1001);
        expect_at(c + 2,  "t5_up",     2'd1, 2'b01, 1'b0, 4'b1001);
        expect_at(c + 10, "t5_pass2",  2'd2, 2'b01, 1'b0, 4'b1001);
        expect_at(c + 18, "t5_open3",  2'd3, 2'b01, 1'b1, 4'b0001);
        expect_at(c + 21, "t5_last3",  2'd3, 2'b01, 1'b1, 4'b0001);
        expect_at(c + 22, "t5_rev",    2'd3, 2'b10, 1'b0, 4'b0001);
        expect_at(c + 30, "t5_down2",  2'd2, 2'b10, 1'b0, 4'b0001);
        expect_at(c + 38, "t5_down1",  2'd1, 2'b10, 1'b0, 4'b0001);
        expect_at(c + 46, "t5_open0",  2'd0, 2'b10, 1'b1, 4'b0000);
        expect_at(c + 50, "t5_idle",   2'd0, 2'b00, 1'b0, 4'b0000);
        pulse(4'b1001);
        wait_until(c + 52);

        // 2: moving up at 1 with calls 3 and 0 pending; floor 2 is never served.
        c = cyc;
        expect_at(c + 2,  "t2_up",     2'd0, 2'b01, 1'b0, 4'b1000);
        expect_at(c + 10, "t2_piso1",  2'd1, 2'b01, 1'b0, 4'b1000);
        expect_at(c + 11, "t2_pend",   2'd1, 2'b01, 1'b0, 4'b1001);
        expect_at(c + 18, "t2_pass2",  2'd2, 2'b01, 1'b0, 4'b1001);
        expect_at(c + 26, "t2_open3",  2'd3, 2'b01, 1'b1, 4'b0001);
        expect_at(c + 30, "t2_rev",    2'd3, 2'b10, 1'b0, 4'b0001);
        expect_at(c + 38, "t2_pass2b", 2'd2, 2'b10, 1'b0, 4'b0001);
        expect_at(c + 46, "t2_down1",  2'd1, 2'b10, 1'b0, 4'b0001);
        expect_at(c + 54, "t2_open0",  2'd0, 2'b10, 1'b1, 4'b0000);
        expect_at(c + 58, "t2_idle",   2'd0, 2'b00, 1'b0, 4'b0000);
        pulse(4'b1000);
        wait_until(c + 10);
        pulse(4'b0001);
        wait_until(c + 60);

        // 6: asynchronous reset mid-travel.
        c = cyc;
        expect_at(c + 10, "t6_piso1",  2'd1, 2'b01, 1'b0, 4'b0100);
        expect_at(c + 15, "t6_pre",    2'd1, 2'b01, 1'b0, 4'b0100);
        pulse(4'b0100);
        wait_until(c + 15);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async", obs(), 9'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        c = cyc;
        expect_at(c + 1,  "t6_rel",    2'd0, 2'b00, 1'b0, 4'b0000);
        expect_at(c + 12, "t6_nomove", 2'd0, 2'b00, 1'b0, 4'b0000);
        wait_until(c + 14);

        // Drain any outstanding expectations within a bounded window.
        for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clk);
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL drain: observed %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
